adc_eth_framer: RTL
===================

Name: adc_eth_framer

Overview:
- Sits between the ADC ping-pong sample buffer (read port, clk125 side) and the RGMII transmit nibble serializer.
- On each bank-completion toggle from the ADC capture stage, reads the finished 1024-byte bank and emits one complete Ethernet II frame as a byte stream with tx_en.
- Frame content: preamble/SFD, fixed MAC header, sequence number, payload, CRC32 FCS, then inter-frame gap.

Parameters:
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC, sent MSB byte first
- SRC_MAC, 48'h0200_0000_0001, source MAC, sent MSB byte first
- ETYPE, 16'h88B5, EtherType
- PAYLOAD_LEN, 1024, payload bytes per frame; must be ≤ 1024
- RD_LAT, 2, buffer read latency in cycles, from rd_addr to valid rd_data
- IFG_LEN, 12, idle cycles after FCS

Ports:
- clk125  in  1  125 MHz byte clock
- rstn  in  1  asynchronous active-low reset
- idx  in  1  bank select from ADC stage (clk50 domain); toggles when a bank completes
- rd_addr  out  11  buffer read address: {bank, offset[9:0]}
- rd_data  in  8  buffer read data
- tx_data  out  8  frame byte
- tx_en  out  1  frame byte valid (RGMII TX_CTL source)
- busy  out  1  high outside IDLE
- seq  out  16  sequence number of the current or last frame
- drop_cnt  out  8  saturating count of dropped triggers

Behaviour:
- Reset values: rd_addr=0, tx_data=0, tx_en=0, busy=0, seq=0, drop_cnt=0, state=IDLE, pending=0.
- idx handling:
  - Passes through a 2-flop synchronizer, then a third flop for edge detection.
  - Any edge on the synchronized idx is a trigger; the bank to send is the synchronized idx value before the edge.
- FSM states: IDLE, PRE, HDR, PAY, FCS, IFG. One byte per cycle; tx_en=1 in PRE through FCS.
  - IDLE: on trigger or pending, latch the bank, clear pending, go to PRE.
  - PRE: 7×0x55, then 0xD5. 8 cycles.
  - HDR: DST_MAC(6), SRC_MAC(6), ETYPE(2), seq(2), all MSB first. 16 cycles.
  - PAY: PAYLOAD_LEN bytes read from offset 0 upward.
  - FCS: 4 bytes, then go to IFG.
  - IFG: IFG_LEN cycles with tx_en=0 and tx_data=0, then return to IDLE.
- Total tx_en-high cycles per frame = 28 + PAYLOAD_LEN (1052 at default).
- Prefetch: rd_addr for payload byte k is presented RD_LAT cycles before that byte goes out. Issue begins inside HDR, so there are no bubbles between HDR and PAY.
- FCS:
  - CRC32 (IEEE 802.3, reflected polynomial 0xEDB88320), init 0xFFFFFFFF.
  - Computed over DST_MAC through the last payload byte.
  - Output is the inverted CRC, LSB byte first.
  - Computed combinationally per byte and registered; available the cycle after the last payload byte.
- seq increments by 1 at each entry to PRE, wrapping 0xFFFF→0x0000. The first frame after reset carries seq=1.
- Trigger while not IDLE:
  - If pending=0, set pending=1 and latch that bank.
  - If pending=1, drop the trigger: increment drop_cnt (saturates at 255) and keep the earlier pending bank.
- Trigger on the same cycle the FSM returns to IDLE: treated as an IDLE trigger, not pending.
- Reset mid-frame: all outputs return to reset values immediately; tx_en drops asynchronously. The truncated frame is left to the PHY as a runt.

Optional Feature:
- FRAMER_TEST_PATTERN_EN
  - Defined: payload byte k = k[7:0] + seq[7:0] (mod 256); rd_addr is still driven but rd_data is ignored. FCS covers the pattern.
  - Undefined: payload is taken from rd_data.

Test Plan:
- Single trigger (idx 0→1) with the bank-0 buffer model holding byte = offset[7:0] → exactly 1052 tx_en cycles.
  - Bytes 0–7 = 55×7, D5.
  - Bytes 8–13 = FF×6; bytes 20–21 = 88 B5; bytes 22–23 = 00 01.
  - Payload reads use rd_addr 0x000–0x3FF.
  - FCS matches the bench CRC32 model and the frame passes a standard FCS check.
  - 12 idle cycles follow.
- Two triggers (idx 1→0, then 0→1) 2000 clk125 cycles apart → two back-to-back frames from bank 1 then bank 0; seq 1 then 2; drop_cnt=0.
- Three triggers within the first 100 cycles of a frame → second frame sent after IFG from the first pending bank; drop_cnt=1.
- Assert rstn low at payload byte 500 → tx_en=0 in the same cycle. After release, seq=0, busy=0, and the next trigger produces seq=1.
- RD_LAT=1 and RD_LAT=3 builds → payload byte k equals the buffer contents at offset k, with no duplicated or skipped bytes.
- FRAMER_TEST_PATTERN_EN with seq=1 → payload 01,02,…,FF,00,…; FCS matches the model.

Source files
------------

// File: rtl/adc_eth_framer.sv
// adc_eth_framer: turns each completed ADC buffer bank into one Ethernet II frame byte stream.
// Optional macro FRAMER_TEST_PATTERN_EN replaces the buffer payload with a seq-offset ramp.
module adc_eth_framer #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [15:0] ETYPE       = 16'h88B5,
    parameter int unsigned PAYLOAD_LEN = 1024,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned IFG_LEN     = 12
) (
    input  logic        clk125,
    input  logic        rstn,
    input  logic        idx,
    output logic [10:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        busy,
    output logic [15:0] seq,
    output logic [7:0]  drop_cnt
);
    typedef enum logic [2:0] {StIdle, StPre, StHdr, StPay, StFcs, StIfg} state_e;

    localparam logic [10:0] PreLast     = 11'd7;
    localparam logic [10:0] HdrLast     = 11'd15;
    localparam logic [10:0] PayLast     = 11'(PAYLOAD_LEN - 1);
    localparam logic [10:0] FcsLast     = 11'd3;
    localparam logic [10:0] IfgLast     = 11'(IFG_LEN - 1);
    localparam logic [10:0] HdrIssue    = 11'(16 - RD_LAT);
    localparam logic [10:0] PayIssueEnd = 11'(PAYLOAD_LEN - 1 - RD_LAT);

    state_e       state_q, state_d;
    logic [10:0]  cnt_q;
    logic         idx_meta_q, idx_sync_q, idx_prev_q;
    logic         trig, trig_bank, start, issue;
    logic         bank_q, pend_q, pend_bank_q;
    logic [9:0]   rd_off_q;
    logic [15:0]  seq_q;
    logic [7:0]   drop_q;
    logic [31:0]  crc_q;
    logic [7:0]   pay_byte;
    logic [127:0] hdr_vec;
    logic [7:0]   hdr_bytes [16];

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk125 or negedge rstn) begin
        if (!rstn) begin
            idx_meta_q <= 1'b0;
            idx_sync_q <= 1'b0;
            idx_prev_q <= 1'b0;
        end else begin
            idx_meta_q <= idx;
            idx_sync_q <= idx_meta_q;
            idx_prev_q <= idx_sync_q;
        end
    end

    // The bank that just completed is the one selected before the toggle.
    assign trig      = idx_sync_q ^ idx_prev_q;
    assign trig_bank = idx_prev_q;

    always_ff @(posedge clk125 or negedge rstn) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trig || pend_q)     state_d = StPre;
            StPre:   if (cnt_q == PreLast)   state_d = StHdr;
            StHdr:   if (cnt_q == HdrLast)   state_d = StPay;
            StPay:   if (cnt_q == PayLast)   state_d = StFcs;
            StFcs:   if (cnt_q == FcsLast)   state_d = StIfg;
            StIfg:   if (cnt_q == IfgLast)   state_d = StIdle;
            default:                         state_d = StIdle;
        endcase
    end

    always_comb begin
        hdr_vec = {DST_MAC, SRC_MAC, ETYPE, seq_q};
        for (int i = 0; i < 16; i++) begin
            hdr_bytes[i] = hdr_vec[8*(15-i) +: 8];
        end
    end

`ifdef FRAMER_TEST_PATTERN_EN
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
    assign pay_byte       = cnt_q[7:0] + seq_q[7:0];
`else
    assign pay_byte = rd_data;
`endif

    always_comb begin
        tx_en   = 1'b0;
        tx_data = 8'h00;
        busy    = (state_q != StIdle);
        unique case (state_q)
            StPre: begin
                tx_en   = 1'b1;
                tx_data = (cnt_q == PreLast) ? 8'hD5 : 8'h55;
            end
            StHdr: begin
                tx_en   = 1'b1;
                tx_data = hdr_bytes[cnt_q[3:0]];
            end
            StPay: begin
                tx_en   = 1'b1;
                tx_data = pay_byte;
            end
            StFcs: begin
                tx_en   = 1'b1;
                tx_data = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    assign start = (state_q == StIdle) && (trig || pend_q);
    // Address for payload byte k is held RD_LAT cycles ahead of its transmit slot.
    assign issue = ((state_q == StHdr) && (cnt_q >= HdrIssue)) ||
                   ((state_q == StPay) && (cnt_q < PayIssueEnd));

    always_ff @(posedge clk125 or negedge rstn) begin
        if (!rstn)                      cnt_q <= '0;
        else if (state_d != state_q)    cnt_q <= '0;
        else if (state_q != StIdle)     cnt_q <= cnt_q + 11'd1;
    end

    always_ff @(posedge clk125 or negedge rstn) begin
        if (!rstn) begin
            seq_q    <= '0;
            rd_off_q <= '0;
            crc_q    <= '1;
        end else if (start) begin
            seq_q    <= seq_q + 16'd1;
            rd_off_q <= '0;
            crc_q    <= '1;
        end else begin
            if (issue) rd_off_q <= rd_off_q + 10'd1;
            if (state_q inside {StHdr, StPay}) crc_q <= crc32_byte(crc_q, tx_data);
        end
    end

    always_ff @(posedge clk125 or negedge rstn) begin
        if (!rstn) begin
            bank_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
            drop_q      <= '0;
        end else if (start) begin
            if (pend_q) begin
                bank_q      <= pend_bank_q;
                pend_q      <= trig;
                pend_bank_q <= trig_bank;
            end else begin
                bank_q <= trig_bank;
            end
        end else if (trig && (state_q != StIdle)) begin
            if (!pend_q) begin
                pend_q      <= 1'b1;
                pend_bank_q <= trig_bank;
            end else if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign rd_addr  = {bank_q, rd_off_q};
    assign seq      = seq_q;
    assign drop_cnt = drop_q;

endmodule
